// File: rtl/rr_sel_arbiter16.sv
// Round-robin arbiter over 16 request lines with bounded grant length and a
// one-cycle idle gap between grants (break-before-make on downstream enables).
//
// state  | meaning
// S_IDLE | no grant; pick next requester starting at ptr
// S_GRANT| sel is live; wait for ack, withdrawal or hold limit
// S_GAP  | one all-idle cycle before re-arbitration
module rr_sel_arbiter16 #(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   input  logic        ack,
   output logic [3:0]  sel,
   output logic        sel_valid,
   output logic        timeout,
   output logic [3:0]  ptr
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;
   logic [3:0]       pick_idx;
   logic [3:0]       scan_idx;
   logic             release_now;

   // Scan from ptr+15 down to ptr so the candidate closest to ptr wins.
   always_comb begin
      pick_idx = ptr;
      scan_idx = '0;
      for (int i = 15; i >= 0; i--) begin
         scan_idx = ptr + 4'(i);
         if (req[scan_idx]) pick_idx = scan_idx;
      end
   end

   assign release_now = ack || !req[sel] || (hold_cnt == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         sel       <= '0;
         sel_valid <= 1'b0;
         timeout   <= 1'b0;
         ptr       <= '0;
         hold_cnt  <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  sel       <= pick_idx;
                  sel_valid <= 1'b1;
                  hold_cnt  <= '0;
                  state     <= S_GRANT;
               end
            end
            S_GRANT: begin
               hold_cnt <= hold_cnt + 1'b1;
               if (release_now) begin
                  sel_valid <= 1'b0;
                  ptr       <= sel + 4'd1;
                  // ack and withdrawal both outrank the forced release
                  timeout   <= !ack && req[sel];
                  state     <= S_GAP;
               end
            end
            S_GAP: begin
               state <= S_IDLE;
            end
            default: begin
               state     <= S_IDLE;
               sel_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_sel_arbiter16.sv
// Directed bench for rr_sel_arbiter16 (HOLD_MAX=4): per-cycle vector table
// plus hand-written reset-mid-grant and full rotation sequences.
module tb_rr_sel_arbiter16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] req;
   logic        ack;
   logic [3:0]  sel;
   logic        sel_valid;
   logic        timeout;
   logic [3:0]  ptr;

   int n_tests = 0;
   int n_fail  = 0;

   rr_sel_arbiter16 #(.HOLD_MAX(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .ack       (ack),
      .sel       (sel),
      .sel_valid (sel_valid),
      .timeout   (timeout),
      .ptr       (ptr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic [15:0] req;
      logic        ack;
      logic [3:0]  sel;
      logic        sv;
      logic        to;
      logic [3:0]  ptr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [15:0] q, input logic a,
                      input logic [3:0] s, input logic v, input logic t,
                      input logic [3:0] p);
      vec_t x;
      x.rst_n = r; x.req = q; x.ack = a;
      x.sel = s; x.sv = v; x.to = t; x.ptr = p;
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Inputs change mid-cycle; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic r, input logic [15:0] q, input logic a);
      @(negedge clk);
      rst_n = r; req = q; ack = a;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string name, input int idx, input logic [3:0] s,
                          input logic v, input logic t, input logic [3:0] p);
      chk({name, ".sel"}, idx, 32'(sel), 32'(s));
      chk({name, ".sel_valid"}, idx, 32'(sel_valid), 32'(v));
      chk({name, ".timeout"}, idx, 32'(timeout), 32'(t));
      chk({name, ".ptr"}, idx, 32'(ptr), 32'(p));
   endtask

   initial begin
      rst_n = 1'b0; req = '0; ack = 1'b0;

      // reset with all requests asserted
      add(0, 16'hFFFF, 0,  0, 0, 0, 0);
      add(0, 16'hFFFF, 0,  0, 0, 0, 0);
      // single request ch5, ack on third grant edge, re-grant after gap
      add(1, 16'h0020, 0,  5, 1, 0, 0);
      add(1, 16'h0020, 0,  5, 1, 0, 0);
      add(1, 16'h0020, 0,  5, 1, 0, 0);
      add(1, 16'h0020, 1,  5, 0, 0, 6);
      add(1, 16'h0020, 0,  5, 0, 0, 6);
      add(1, 16'h0020, 0,  5, 1, 0, 6);
      add(1, 16'h0020, 1,  5, 0, 0, 6);
      add(1, 16'h0000, 0,  5, 0, 0, 6);
      add(1, 16'h0000, 0,  5, 0, 0, 6);
      // timeout: ch8 held 4 cycles, no ack
      add(1, 16'h0100, 0,  8, 1, 0, 6);
      add(1, 16'h0100, 0,  8, 1, 0, 6);
      add(1, 16'h0100, 0,  8, 1, 0, 6);
      add(1, 16'h0100, 0,  8, 1, 0, 6);
      add(1, 16'h0100, 0,  8, 0, 1, 9);
      add(1, 16'h0100, 0,  8, 0, 0, 9);
      // same, ack arrives on the 4th cycle: no timeout pulse
      add(1, 16'h0100, 0,  8, 1, 0, 9);
      add(1, 16'h0100, 0,  8, 1, 0, 9);
      add(1, 16'h0100, 0,  8, 1, 0, 9);
      add(1, 16'h0100, 0,  8, 1, 0, 9);
      add(1, 16'h0100, 1,  8, 0, 0, 9);
      add(1, 16'h0000, 0,  8, 0, 0, 9);
      // bring ptr to 2 via ch1 grant
      add(1, 16'h0002, 0,  1, 1, 0, 9);
      add(1, 16'h0002, 1,  1, 0, 0, 2);
      add(1, 16'h8003, 0,  1, 0, 0, 2);
      // withdraw and skip: 8003 from ptr=2 -> 15, drop 15 -> release, then 0
      add(1, 16'h8003, 0, 15, 1, 0, 2);
      add(1, 16'h0003, 0, 15, 0, 0, 0);
      add(1, 16'h0003, 0, 15, 0, 0, 0);
      add(1, 16'h0003, 0,  0, 1, 0, 0);
      add(1, 16'h0003, 1,  0, 0, 0, 1);
      add(1, 16'h0000, 0,  0, 0, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst_n, vecs[i].req, vecs[i].ack);
         chk_all("vec", i, vecs[i].sel, vecs[i].sv, vecs[i].to, vecs[i].ptr);
      end

      // reset mid-grant on ch9, then 0201 from ptr=0 grants ch0
      step(1, 16'h0200, 0);
      chk_all("mid_grant", 0, 9, 1, 0, 1);
      step(1, 16'h0200, 0);
      chk_all("mid_grant", 1, 9, 1, 0, 1);
      step(0, 16'h0200, 0);
      chk_all("mid_reset", 0, 0, 0, 0, 0);
      step(1, 16'h0201, 0);
      chk_all("post_reset", 0, 0, 1, 0, 0);
      step(1, 16'h0201, 1);
      chk_all("post_reset", 1, 0, 0, 0, 1);
      step(1, 16'h0000, 0);
      chk_all("post_reset", 2, 0, 0, 0, 1);

      // rotation over all channels with wrap back to 0
      step(0, 16'h0000, 0);
      for (int k = 0; k <= 16; k++) begin
         logic [3:0] ch;
         ch = 4'(k % 16);
         step(1, 16'hFFFF, 0);
         chk_all("rot_grant", k, ch, 1, 0, ch);
         step(1, 16'hFFFF, 1);
         chk_all("rot_rel", k, ch, 0, 0, ch + 4'd1);
         step(1, 16'hFFFF, 0);
         chk_all("rot_gap", k, ch, 0, 0, ch + 4'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
